fetch_queue: RTL and testbench

Parametrised fetch stage with a decoupling prefetch queue. Issues sequential instruction reads to the memory system, one outstanding request at a time, and buffers returned words with their PC+INC in a DEPTH-entry FIFO, so decode stalls and cache misses overlap. Supports redirect (branch/jump) with queue flush and discard of an in-flight response. Sits between the PC-select logic and decode; replaces the single-register PC fetch.

---
 rtl/fetch_queue.sv | 192 +++++++++++++++++++
 tb/tb_fetch_queue.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: sequential instruction fetch with a DEPTH-entry prefetch queue.
// One read is outstanding at a time. Returned words are queued together with
// their PC+INC so that decode stalls and memory latency overlap. A redirect
// flushes the queue, restarts fetch at redirectPC, and discards any response
// still in flight.
//
// Optional build macro:
//   FETCH_BYPASS_EN - when the queue is empty, a returning word is presented
//                     on instr/PC2/instrValid in the same cycle as memDone.
//
// Ports:
//   clk, rst          clock; asynchronous active-low reset
//   redirect          flush queue and restart fetch at redirectPC
//   redirectPC        new fetch address
//   halt              stop issuing new reads (in-flight read still completes)
//   stall             decode cannot accept the head entry this cycle
//   memRd, memAddr    read request to memory (combinational)
//   memStall          memory did not accept the request this cycle
//   memDone, memData  read response
//   instr, PC2        queue head instruction and its PC + INC
//   instrValid        queue head valid
//   err               sticky flag: redirect to an address not a multiple of INC
module fetch_queue #(
    parameter int unsigned       WIDTH    = 16,
    parameter int unsigned       DEPTH    = 4,
    parameter logic [WIDTH-1:0]  RESET_PC = '0,
    parameter int unsigned       INC      = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirectPC,
    input  logic             halt,
    input  logic             stall,
    output logic             memRd,
    output logic [WIDTH-1:0] memAddr,
    input  logic             memStall,
    input  logic             memDone,
    input  logic [WIDTH-1:0] memData,
    output logic [WIDTH-1:0] instr,
    output logic [WIDTH-1:0] PC2,
    output logic             instrValid,
    output logic             err
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic             drop_q, drop_d;
    logic             err_q, err_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] instr_mem_q [DEPTH];
    logic [WIDTH-1:0] pc2_mem_q   [DEPTH];

    logic [WIDTH-1:0] pc_inc;
    logic             fifo_empty;
    logic             fifo_full;
    logic             resp_ok;
    logic             byp_valid;
    logic             byp_take;
    logic             push;
    logic             pop;

    // Address of the next sequential instruction; wraps modulo 2^WIDTH.
    assign pc_inc     = fetch_pc_q + INC_W;
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNT_W'(DEPTH));

    // A response is kept only if it was not orphaned by an earlier redirect
    // and is not cancelled by a redirect in this very cycle.
    assign resp_ok = (state_q == S_WAIT) & memDone & ~drop_q & ~redirect;

`ifdef FETCH_BYPASS_EN
    assign byp_valid = fifo_empty & resp_ok;
`else
    assign byp_valid = 1'b0;
`endif

    // A bypassed word consumed by decode never enters the queue.
    assign byp_take = byp_valid & ~stall;
    assign push     = resp_ok & ~byp_take;
    assign pop      = ~fifo_empty & ~stall & ~redirect;

    // Issue only while a queue slot is free, so the eventual push always fits.
    assign memRd   = rst & (state_q == S_IDLE) & ~fifo_full & ~halt & ~redirect;
    assign memAddr = fetch_pc_q;

    assign instrValid = ~fifo_empty | byp_valid;
    assign instr      = byp_valid ? memData : instr_mem_q[rd_ptr_q];
    assign PC2        = byp_valid ? pc_inc  : pc2_mem_q[rd_ptr_q];
    assign err        = err_q;

    // Next-state logic: fetch FSM, queue pointers and occupancy, redirect.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        drop_d     = drop_q;
        err_d      = err_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;

        case (state_q)
            S_IDLE: begin
                if (memRd && !memStall) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (memDone) begin
                    state_d = S_IDLE;
                    drop_d  = 1'b0;
                    if (resp_ok) begin
                        fetch_pc_d = pc_inc;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // Redirect wins over push/pop; a still-pending read is marked for discard.
        if (redirect) begin
            fetch_pc_d = redirectPC;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            if ((state_q == S_WAIT) && !memDone) begin
                drop_d = 1'b1;
            end
            if ((redirectPC % INC_W) != '0) begin
                err_d = 1'b1;
            end
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC;
            drop_q     <= 1'b0;
            err_q      <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            drop_q     <= drop_d;
            err_q      <= err_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // Queue storage; cleared on reset so the head reads as zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                instr_mem_q[i] <= '0;
                pc2_mem_q[i]   <= '0;
            end
        end else if (push) begin
            instr_mem_q[wr_ptr_q] <= memData;
            pc2_mem_q[wr_ptr_q]   <= pc_inc;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue (default build, WIDTH=16, DEPTH=4, INC=2).
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect;
    logic [15:0] redirectPC;
    logic        halt;
    logic        stall;
    logic        memRd;
    logic [15:0] memAddr;
    logic        memStall;
    logic        memDone;
    logic [15:0] memData;
    logic [15:0] instr;
    logic [15:0] PC2;
    logic        instrValid;
    logic        err;

    int errors = 0;
    int checks = 0;

    // Memory model controls
    int  mem_lat       = 1;
    bit  mem_lat_rand  = 1'b0;
    int  mem_stall_pct = 0;
    bit  stall_force   = 1'b0;
    bit  force_en      = 1'b0;
    int  proto_err     = 0;

    fetch_queue #(
        .WIDTH(16), .DEPTH(4), .RESET_PC(16'h0000), .INC(2)
    ) dut (
        .clk(clk), .rst(rst), .redirect(redirect), .redirectPC(redirectPC),
        .halt(halt), .stall(stall), .memRd(memRd), .memAddr(memAddr),
        .memStall(memStall), .memDone(memDone), .memData(memData),
        .instr(instr), .PC2(PC2), .instrValid(instrValid), .err(err)
    );

    always #5 clk = ~clk;

    // Memory contents: a bijective scramble of the address.
    function automatic logic [15:0] hword(input logic [15:0] a);
        logic [31:0] p;
        p = 32'(a) * 32'h0000_9E37;
        return p[15:0] ^ 16'h5A5A;
    endfunction

    // Memory responder: accepts at most one read, answers after a latency.
    initial begin : mem_model
        bit          pending;
        int          remaining;
        logic [15:0] paddr;
        pending = 1'b0; remaining = 0; paddr = '0;
        memStall = 1'b0; memDone = 1'b0; memData = '0;
        forever begin
            @(negedge clk);
            if (rst !== 1'b1) begin
                pending = 1'b0;
            end else begin
                if (memDone) pending = 1'b0;
                if (memRd && !memStall) begin
                    if (pending) proto_err++;
                    pending   = 1'b1;
                    remaining = mem_lat_rand ? int'($urandom_range(1, 3)) : mem_lat;
                    paddr     = memAddr;
                end
            end
            @(posedge clk);
            #1;
            memDone = 1'b0;
            memData = 16'($urandom);
            if (pending && rst === 1'b1) begin
                remaining--;
                if (remaining <= 0) begin
                    memDone = 1'b1;
                    memData = force_en ? 16'hDEAD : hword(paddr);
                end
            end
            memStall = stall_force ||
                       (mem_stall_pct > 0 && int'($urandom_range(0, 99)) < mem_stall_pct);
        end
    end

    // Applies reset and returns at the start of the first cycle after release.
    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b0; redirect = 1'b0; halt = 1'b0; stall = 1'b0;
        stall_force = 1'b0; force_en = 1'b0; mem_lat = 1; mem_lat_rand = 1'b0;
        mem_stall_pct = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (memRd !== 1'b0) begin errors++; $display("FAIL reset_memRd: got %b want 0", memRd); end
        checks++; if (instrValid !== 1'b0) begin errors++; $display("FAIL reset_instrValid: got %b want 0", instrValid); end
        checks++; if (instr !== 16'h0000) begin errors++; $display("FAIL reset_instr: got %h want 0000", instr); end
        checks++; if (PC2 !== 16'h0000) begin errors++; $display("FAIL reset_PC2: got %h want 0000", PC2); end
        checks++; if (memAddr !== 16'h0000) begin errors++; $display("FAIL reset_memAddr: got %h want 0000", memAddr); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        checks++;
        if (memRd !== 1'b1 || memAddr !== 16'h0000) begin
            errors++; $display("FAIL first_req: got rd=%b addr=%h want rd=1 addr=0000", memRd, memAddr);
        end
    endtask

    task automatic test_sequential();
        logic [15:0] exp_issue, exp_pc;
        int pops;
        do_reset();
        exp_issue = '0; exp_pc = '0; pops = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (memRd && !memStall) begin
                checks++;
                if (memAddr !== exp_issue) begin errors++; $display("FAIL seq_addr: got %h want %h", memAddr, exp_issue); end
                exp_issue = exp_issue + 16'd2;
            end
            if (instrValid) begin
                checks++;
                if (instr !== hword(exp_pc) || PC2 !== 16'(exp_pc + 16'd2)) begin
                    errors++; $display("FAIL seq_word: got %h/%h want %h/%h", instr, PC2, hword(exp_pc), 16'(exp_pc + 16'd2));
                end
                exp_pc = exp_pc + 16'd2;
                pops++;
            end
        end
        checks++; if (pops != 5) begin errors++; $display("FAIL seq_throughput: got %0d words want 5", pops); end
    endtask

    task automatic test_stall_full();
        int nreq, bad;
        bit saw_rd;
        do_reset();
        stall = 1'b1;
        nreq = 0; bad = 0; saw_rd = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (memRd && !memStall) nreq++;
            if (instrValid && (instr !== hword(16'h0000) || PC2 !== 16'h0002)) bad++;
        end
        checks++; if (nreq != 4) begin errors++; $display("FAIL full_reqs: got %0d want 4", nreq); end
        checks++; if (bad != 0) begin errors++; $display("FAIL full_head_stable: got %0d changes want 0", bad); end
        checks++; if (memRd !== 1'b0) begin errors++; $display("FAIL full_memRd: got %b want 0", memRd); end
        checks++; if (instrValid !== 1'b1) begin errors++; $display("FAIL full_valid: got %b want 1", instrValid); end
        @(posedge clk);
        #1 stall = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (instrValid !== 1'b1 || instr !== hword(16'(2 * k)) || PC2 !== 16'(2 * k + 2)) begin
                errors++; $display("FAIL drain_%0d: got v=%b %h/%h want v=1 %h/%h", k, instrValid, instr, PC2,
                                   hword(16'(2 * k)), 16'(2 * k + 2));
            end
            if (memRd) saw_rd = 1'b1;
        end
        checks++; if (!saw_rd) begin errors++; $display("FAIL drain_resume: got no memRd want memRd"); end
    endtask

    task automatic test_redirect_wait();
        logic [15:0] first_addr, word, wpc2;
        bit addr_seen, got_word, seen_dead;
        do_reset();
        mem_lat = 4; force_en = 1'b1;
        @(negedge clk);
        checks++;
        if (memRd !== 1'b1 || memAddr !== 16'h0000) begin
            errors++; $display("FAIL rdw_issue: got rd=%b addr=%h want rd=1 addr=0000", memRd, memAddr);
        end
        @(posedge clk);
        #1 redirect = 1'b1; redirectPC = 16'h0100;
        @(negedge clk);
        checks++; if (memRd !== 1'b0) begin errors++; $display("FAIL rdw_no_issue: got %b want 0", memRd); end
        @(posedge clk);
        #1 redirect = 1'b0;
        @(negedge clk);
        checks++; if (instrValid !== 1'b0) begin errors++; $display("FAIL rdw_empty: got %b want 0", instrValid); end
        addr_seen = 1'b0; got_word = 1'b0; seen_dead = 1'b0; first_addr = '0; word = '0; wpc2 = '0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (instrValid && instr === 16'hDEAD) seen_dead = 1'b1;
            if (memRd && !memStall && !addr_seen) begin
                addr_seen = 1'b1; first_addr = memAddr; force_en = 1'b0;
            end
            if (instrValid && !got_word) begin got_word = 1'b1; word = instr; wpc2 = PC2; end
        end
        checks++; if (seen_dead) begin errors++; $display("FAIL rdw_dropped: got DEAD on instr want never"); end
        checks++; if (!addr_seen || first_addr !== 16'h0100) begin errors++; $display("FAIL rdw_addr: got %h want 0100", first_addr); end
        checks++;
        if (!got_word || word !== hword(16'h0100) || wpc2 !== 16'h0102) begin
            errors++; $display("FAIL rdw_word: got %h/%h want %h/0102", word, wpc2, hword(16'h0100));
        end
    endtask

    task automatic test_misaligned();
        logic [15:0] first_addr, word, wpc2;
        bit addr_seen, got_word;
        do_reset();
        redirect = 1'b1; redirectPC = 16'h0101;
        @(posedge clk);
        #1 redirect = 1'b0;
        @(negedge clk);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL mis_err_set: got %b want 1", err); end
        addr_seen = 1'b0; got_word = 1'b0; first_addr = '0; word = '0; wpc2 = '0;
        for (int c = 0; c < 10; c++) begin
            if (c > 0) @(negedge clk);
            if (memRd && !memStall && !addr_seen) begin addr_seen = 1'b1; first_addr = memAddr; end
            if (instrValid && !got_word) begin got_word = 1'b1; word = instr; wpc2 = PC2; end
        end
        checks++; if (first_addr !== 16'h0101) begin errors++; $display("FAIL mis_addr: got %h want 0101", first_addr); end
        checks++;
        if (!got_word || word !== hword(16'h0101) || wpc2 !== 16'h0103) begin
            errors++; $display("FAIL mis_word: got %h/%h want %h/0103", word, wpc2, hword(16'h0101));
        end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL mis_err_sticky: got %b want 1", err); end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL mis_err_clear: got %b want 0", err); end
    endtask

    task automatic test_halt_memstall();
        int bad_rd, nwords, bad_word, bad_hold;
        do_reset();
        mem_lat = 2;
        @(posedge clk);
        #1 halt = 1'b1;
        bad_rd = 0; nwords = 0; bad_word = 0; bad_hold = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (memRd) bad_rd++;
            if (instrValid) begin
                nwords++;
                if (instr !== hword(16'h0000) || PC2 !== 16'h0002) bad_word++;
            end
        end
        checks++; if (bad_rd != 0) begin errors++; $display("FAIL halt_no_issue: got %0d requests want 0", bad_rd); end
        checks++; if (nwords != 1 || bad_word != 0) begin errors++; $display("FAIL halt_pending: got %0d words (%0d bad) want 1", nwords, bad_word); end
        checks++; if (instrValid !== 1'b0) begin errors++; $display("FAIL halt_drained: got %b want 0", instrValid); end
        stall_force = 1'b1;
        @(posedge clk);
        #1 halt = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (memRd !== 1'b1 || memAddr !== 16'h0002) bad_hold++;
        end
        stall_force = 1'b0;
        checks++; if (bad_hold != 0) begin errors++; $display("FAIL memstall_hold: got %0d bad cycles want 0", bad_hold); end
    endtask

    task automatic test_wrap();
        logic [15:0] addrs [2];
        logic [15:0] words [2];
        logic [15:0] pcs   [2];
        int na, nw;
        do_reset();
        redirect = 1'b1; redirectPC = 16'hFFFE;
        @(posedge clk);
        #1 redirect = 1'b0;
        na = 0; nw = 0;
        addrs[0] = '0; addrs[1] = '0; words[0] = '0; words[1] = '0; pcs[0] = '0; pcs[1] = '0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (memRd && !memStall && na < 2) begin addrs[na] = memAddr; na++; end
            if (instrValid && nw < 2) begin words[nw] = instr; pcs[nw] = PC2; nw++; end
        end
        checks++;
        if (addrs[0] !== 16'hFFFE || addrs[1] !== 16'h0000) begin
            errors++; $display("FAIL wrap_addr: got %h,%h want fffe,0000", addrs[0], addrs[1]);
        end
        checks++;
        if (words[0] !== hword(16'hFFFE) || pcs[0] !== 16'h0000) begin
            errors++; $display("FAIL wrap_word0: got %h/%h want %h/0000", words[0], pcs[0], hword(16'hFFFE));
        end
        checks++;
        if (words[1] !== hword(16'h0000) || pcs[1] !== 16'h0002) begin
            errors++; $display("FAIL wrap_word1: got %h/%h want %h/0002", words[1], pcs[1], hword(16'h0000));
        end
    endtask

    task automatic test_random();
        logic [15:0] exp_pc, exp_issue;
        bit err_exp;
        int pops;
        do_reset();
        mem_lat_rand = 1'b1; mem_stall_pct = 25;
        exp_pc = '0; exp_issue = '0; err_exp = 1'b0; pops = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (redirect) begin
                checks++;
                if (memRd !== 1'b0) begin errors++; $display("FAIL rnd_redirect_issue: got %b want 0 (cycle %0d)", memRd, c); end
                exp_pc = redirectPC; exp_issue = redirectPC;
            end else begin
                if (memRd && !memStall) begin
                    checks++;
                    if (memAddr !== exp_issue) begin errors++; $display("FAIL rnd_addr: got %h want %h (cycle %0d)", memAddr, exp_issue, c); end
                    exp_issue = exp_issue + 16'd2;
                end
                if (instrValid && !stall) begin
                    checks++;
                    if (instr !== hword(exp_pc) || PC2 !== 16'(exp_pc + 16'd2)) begin
                        errors++; $display("FAIL rnd_word: got %h/%h want %h/%h (cycle %0d)", instr, PC2,
                                           hword(exp_pc), 16'(exp_pc + 16'd2), c);
                    end
                    exp_pc = exp_pc + 16'd2;
                    pops++;
                end
            end
            @(posedge clk);
            #1;
            stall    = (int'($urandom_range(0, 99)) < 30);
            halt     = (int'($urandom_range(0, 99)) < 10);
            redirect = (int'($urandom_range(0, 99)) < 3);
            if (redirect) begin
                redirectPC = 16'($urandom) & 16'hFFFE;
                if ($urandom_range(0, 19) == 0) begin
                    redirectPC = redirectPC | 16'h0001;
                    err_exp = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1; stall = 1'b0; halt = 1'b0; redirect = 1'b0;
        checks++; if (proto_err != 0) begin errors++; $display("FAIL rnd_one_outstanding: got %0d overlaps want 0", proto_err); end
        checks++; if (err !== err_exp) begin errors++; $display("FAIL rnd_err: got %b want %b", err, err_exp); end
        checks++; if (pops < 200) begin errors++; $display("FAIL rnd_progress: got %0d words want >=200", pops); end
    endtask

    initial begin
        rst = 1'b0; redirect = 1'b0; redirectPC = '0; halt = 1'b0; stall = 1'b0;
        test_reset();
        test_sequential();
        test_stall_full();
        test_redirect_wait();
        test_misaligned();
        test_halt_memstall();
        test_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
